// File: rtl/rs_station.sv
// Reservation station: holds issued instructions until both operands resolve,
// snoops all CDB channels, and dispatches the oldest ready entry to one execution unit.
module rs_station #(
  parameter int Q_WIDTH  = 4,
  parameter int RS_DEPTH = 16,
  parameter int CDB_NUM  = 2,
  parameter int OP_WIDTH = 10
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic                          flush_in,
  input  logic                          issue_valid_in,
  output logic                          issue_ready_out,
  input  logic [Q_WIDTH-1:0]            issue_tag_in,
  input  logic [OP_WIDTH-1:0]           issue_op_in,
  input  logic [Q_WIDTH-1:0]            issue_q1_in,
  input  logic [Q_WIDTH-1:0]            issue_q2_in,
  input  logic [31:0]                   issue_v1_in,
  input  logic [31:0]                   issue_v2_in,
  input  logic [31:0]                   issue_imm_in,
  input  logic [31:0]                   issue_npc_in,
  input  logic [CDB_NUM-1:0]            cdb_valid_in,
  input  logic [CDB_NUM*Q_WIDTH-1:0]    cdb_tag_in,
  input  logic [CDB_NUM*32-1:0]         cdb_value_in,
  output logic                          ex_valid_out,
  input  logic                          ex_ready_in,
  output logic [OP_WIDTH-1:0]           ex_op_out,
  output logic [31:0]                   ex_v1_out,
  output logic [31:0]                   ex_v2_out,
  output logic [31:0]                   ex_imm_out,
  output logic [31:0]                   ex_npc_out,
  output logic [Q_WIDTH-1:0]            ex_tag_out,
  output logic [$clog2(RS_DEPTH+1)-1:0] count_out
);
  localparam int CW = $clog2(RS_DEPTH + 1);
  localparam int RW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  logic                busy_q [RS_DEPTH];
  logic [Q_WIDTH-1:0]  tag_q  [RS_DEPTH];
  logic [OP_WIDTH-1:0] op_q   [RS_DEPTH];
  logic [Q_WIDTH-1:0]  q1_q   [RS_DEPTH];
  logic [Q_WIDTH-1:0]  q2_q   [RS_DEPTH];
  logic [31:0]         v1_q   [RS_DEPTH];
  logic [31:0]         v2_q   [RS_DEPTH];
  logic [31:0]         imm_q  [RS_DEPTH];
  logic [31:0]         npc_q  [RS_DEPTH];
  logic [RW-1:0]       rank_q [RS_DEPTH];

  logic                ex_valid_q;
  logic [OP_WIDTH-1:0] ex_op_q;
  logic [31:0]         ex_v1_q, ex_v2_q, ex_imm_q, ex_npc_q;
  logic [Q_WIDTH-1:0]  ex_tag_q;
  logic [CW-1:0]       count_q;

  logic [32:0]   wk1 [RS_DEPTH];
  logic [32:0]   wk2 [RS_DEPTH];
  logic [32:0]   is1, is2;
  logic          sel_any;
  logic [RW-1:0] sel_idx, sel_rank, free_idx, new_rank;
  logic [CW-1:0] cnt_after_sel;
  logic          adv, ex_take, sel_fire, issue_acc;

  // {hit, value}; scanning high-to-low lets the lowest matching channel win.
  function automatic logic [32:0] snoop(input logic [Q_WIDTH-1:0]         q,
                                        input logic [CDB_NUM-1:0]         vld,
                                        input logic [CDB_NUM*Q_WIDTH-1:0] tags,
                                        input logic [CDB_NUM*32-1:0]      vals);
    logic [32:0] r;
    r = '0;
    for (int k = CDB_NUM - 1; k >= 0; k--)
      if (q != '0 && vld[k] && tags[k*Q_WIDTH +: Q_WIDTH] == q)
        r = {1'b1, vals[k*32 +: 32]};
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      wk1[i] = snoop(q1_q[i], cdb_valid_in, cdb_tag_in, cdb_value_in);
      wk2[i] = snoop(q2_q[i], cdb_valid_in, cdb_tag_in, cdb_value_in);
    end
    is1 = snoop(issue_q1_in, cdb_valid_in, cdb_tag_in, cdb_value_in);
    is2 = snoop(issue_q2_in, cdb_valid_in, cdb_tag_in, cdb_value_in);
  end

  // Ranks of busy entries are always 0..count-1; rank 0 is the oldest.
  always_comb begin
    sel_any  = 1'b0;
    sel_idx  = '0;
    sel_rank = '0;
    free_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (busy_q[i] && q1_q[i] == '0 && q2_q[i] == '0 &&
          (!sel_any || rank_q[i] < sel_rank)) begin
        sel_any  = 1'b1;
        sel_idx  = RW'(i);
        sel_rank = rank_q[i];
      end
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!busy_q[i]) free_idx = RW'(i);
  end

  assign issue_ready_out = rdy_in && (count_q < CW'(RS_DEPTH));
  assign adv            = rdy_in && !flush_in;
  assign ex_take        = adv && (!ex_valid_q || ex_ready_in);
  assign sel_fire       = ex_take && sel_any;
  assign issue_acc      = adv && issue_valid_in && issue_ready_out;
  assign cnt_after_sel  = count_q - CW'(sel_fire);
  assign new_rank       = cnt_after_sel[RW-1:0];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
        op_q[i]   <= '0;
        q1_q[i]   <= '0;
        q2_q[i]   <= '0;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
        imm_q[i]  <= '0;
        npc_q[i]  <= '0;
        rank_q[i] <= '0;
      end
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_v1_q    <= '0;
      ex_v2_q    <= '0;
      ex_imm_q   <= '0;
      ex_npc_q   <= '0;
      ex_tag_q   <= '0;
      count_q    <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < RS_DEPTH; i++) busy_q[i] <= 1'b0;
        ex_valid_q <= 1'b0;
        count_q    <= '0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (busy_q[i] && wk1[i][32]) begin
            q1_q[i] <= '0;
            v1_q[i] <= wk1[i][31:0];
          end
          if (busy_q[i] && wk2[i][32]) begin
            q2_q[i] <= '0;
            v2_q[i] <= wk2[i][31:0];
          end
          if (sel_fire && busy_q[i] && rank_q[i] > sel_rank)
            rank_q[i] <= rank_q[i] - 1'b1;
        end
        if (sel_fire) busy_q[sel_idx] <= 1'b0;
        if (issue_acc) begin
          busy_q[free_idx] <= 1'b1;
          tag_q[free_idx]  <= issue_tag_in;
          op_q[free_idx]   <= issue_op_in;
          q1_q[free_idx]   <= is1[32] ? '0 : issue_q1_in;
          q2_q[free_idx]   <= is2[32] ? '0 : issue_q2_in;
          v1_q[free_idx]   <= is1[32] ? is1[31:0] : issue_v1_in;
          v2_q[free_idx]   <= is2[32] ? is2[31:0] : issue_v2_in;
          imm_q[free_idx]  <= issue_imm_in;
          npc_q[free_idx]  <= issue_npc_in;
          rank_q[free_idx] <= new_rank;
        end
        if (ex_take) begin
          ex_valid_q <= sel_any;
          if (sel_any) begin
            ex_op_q  <= op_q[sel_idx];
            ex_v1_q  <= v1_q[sel_idx];
            ex_v2_q  <= v2_q[sel_idx];
            ex_imm_q <= imm_q[sel_idx];
            ex_npc_q <= npc_q[sel_idx];
            ex_tag_q <= tag_q[sel_idx];
          end
        end
        count_q <= cnt_after_sel + CW'(issue_acc);
      end
    end
  end

  assign ex_valid_out = ex_valid_q;
  assign ex_op_out    = ex_op_q;
  assign ex_v1_out    = ex_v1_q;
  assign ex_v2_out    = ex_v2_q;
  assign ex_imm_out   = ex_imm_q;
  assign ex_npc_out   = ex_npc_q;
  assign ex_tag_out   = ex_tag_q;
  assign count_out    = count_q;

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: issue, wake-up, age order, full, bypass, enable, flush, reset.
module tb_rs_station;
  localparam int QW = 4, D = 16, CN = 2, OW = 10, CW = $clog2(D + 1);

  logic              clk_in = 1'b0;
  logic              rst_n_in, rdy_in, flush_in, issue_valid_in, ex_ready_in;
  logic              issue_ready_out, ex_valid_out;
  logic [QW-1:0]     issue_tag_in, issue_q1_in, issue_q2_in, ex_tag_out;
  logic [OW-1:0]     issue_op_in, ex_op_out;
  logic [31:0]       issue_v1_in, issue_v2_in, issue_imm_in, issue_npc_in;
  logic [CN-1:0]     cdb_valid_in;
  logic [CN*QW-1:0]  cdb_tag_in;
  logic [CN*32-1:0]  cdb_value_in;
  logic [31:0]       ex_v1_out, ex_v2_out, ex_imm_out, ex_npc_out;
  logic [CW-1:0]     count_out;

  int n_cmp  = 0;
  int n_fail = 0;

  rs_station #(.Q_WIDTH(QW), .RS_DEPTH(D), .CDB_NUM(CN), .OP_WIDTH(OW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_valid_in(issue_valid_in), .issue_ready_out(issue_ready_out),
    .issue_tag_in(issue_tag_in), .issue_op_in(issue_op_in),
    .issue_q1_in(issue_q1_in), .issue_q2_in(issue_q2_in),
    .issue_v1_in(issue_v1_in), .issue_v2_in(issue_v2_in),
    .issue_imm_in(issue_imm_in), .issue_npc_in(issue_npc_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .ex_valid_out(ex_valid_out), .ex_ready_in(ex_ready_in),
    .ex_op_out(ex_op_out), .ex_v1_out(ex_v1_out), .ex_v2_out(ex_v2_out),
    .ex_imm_out(ex_imm_out), .ex_npc_out(ex_npc_out), .ex_tag_out(ex_tag_out),
    .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle();
    issue_valid_in = 1'b0; issue_tag_in = '0; issue_op_in = '0;
    issue_q1_in = '0; issue_q2_in = '0; issue_v1_in = '0; issue_v2_in = '0;
    issue_imm_in = '0; issue_npc_in = '0;
    cdb_valid_in = '0; cdb_tag_in = '0; cdb_value_in = '0; flush_in = 1'b0;
  endtask

  task automatic set_issue(input logic [QW-1:0] tag, q1, q2, input logic [31:0] v1, v2);
    issue_valid_in = 1'b1; issue_tag_in = tag; issue_op_in = OW'(tag) + 10'h30;
    issue_q1_in = q1; issue_q2_in = q2; issue_v1_in = v1; issue_v2_in = v2;
    issue_imm_in = 32'h100 + 32'(tag); issue_npc_in = 32'h2000 + 32'(tag);
  endtask

  task automatic set_cdb(input logic [CN-1:0] vld, input logic [QW-1:0] t0, t1,
                         input logic [31:0] d0, d1);
    cdb_valid_in = vld; cdb_tag_in = {t1, t0}; cdb_value_in = {d1, d0};
  endtask

  task automatic test_reset();
    idle(); rdy_in = 1'b1; ex_ready_in = 1'b0; rst_n_in = 1'b0;
    #12;
    n_cmp++; if (ex_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_exv: got %0h want 0", ex_valid_out); end
    n_cmp++; if (count_out !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", count_out); end
    n_cmp++; if (issue_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_irdy: got %0h want 1", issue_ready_out); end
    n_cmp++; if ({ex_tag_out, ex_v1_out, ex_npc_out} !== '0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", {ex_tag_out, ex_v1_out, ex_npc_out}); end
    @(negedge clk_in); rst_n_in = 1'b1;
  endtask

  task automatic test_basic();
    ex_ready_in = 1'b1;
    set_issue(3, 0, 0, 5, 7); step(); idle();
    n_cmp++; if (count_out !== 5'd1 || ex_valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_load: got cnt %0d exv %0h want 1 0", count_out, ex_valid_out); end
    step();
    n_cmp++; if (ex_valid_out !== 1'b1 || ex_tag_out !== 4'd3) begin n_fail++; $display("FAIL basic_disp: got exv %0h tag %0d want 1 3", ex_valid_out, ex_tag_out); end
    n_cmp++; if (ex_v1_out !== 32'd5 || ex_v2_out !== 32'd7) begin n_fail++; $display("FAIL basic_vals: got %0h %0h want 5 7", ex_v1_out, ex_v2_out); end
    n_cmp++; if (ex_op_out !== 10'h33 || ex_imm_out !== 32'h103 || ex_npc_out !== 32'h2003) begin n_fail++; $display("FAIL basic_fields: got %0h %0h %0h want 33 103 2003", ex_op_out, ex_imm_out, ex_npc_out); end
    n_cmp++; if (count_out !== 5'd0) begin n_fail++; $display("FAIL basic_cnt: got %0d want 0", count_out); end
    step();
    n_cmp++; if (ex_valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %0h want 0", ex_valid_out); end
  endtask

  task automatic test_wakeup();
    ex_ready_in = 1'b1;
    set_issue(4, 2, 0, 32'hDEAD, 1); step();
    set_issue(5, 0, 0, 32'h50, 0); step(); idle();
    n_cmp++; if (count_out !== 5'd2 || ex_valid_out !== 1'b0) begin n_fail++; $display("FAIL wake_wait: got cnt %0d exv %0h want 2 0", count_out, ex_valid_out); end
    set_cdb(2'b10, 0, 2, 0, 32'h1234); step(); idle();
    n_cmp++; if (ex_valid_out !== 1'b1 || ex_tag_out !== 4'd5 || count_out !== 5'd1) begin n_fail++; $display("FAIL wake_first: got exv %0h tag %0d cnt %0d want 1 5 1", ex_valid_out, ex_tag_out, count_out); end
    step();
    n_cmp++; if (ex_tag_out !== 4'd4 || ex_v1_out !== 32'h1234 || ex_v2_out !== 32'd1) begin n_fail++; $display("FAIL wake_second: got tag %0d v1 %0h v2 %0h want 4 1234 1", ex_tag_out, ex_v1_out, ex_v2_out); end
    step();
    n_cmp++; if (ex_valid_out !== 1'b0 || count_out !== 5'd0) begin n_fail++; $display("FAIL wake_end: got exv %0h cnt %0d want 0 0", ex_valid_out, count_out); end
  endtask

  // Entry indices end up B=0, A=1, C=2, so index order differs from age order.
  task automatic test_age();
    logic [QW-1:0] exp_tags [3];
    exp_tags[0] = 4'd10; exp_tags[1] = 4'd11; exp_tags[2] = 4'd12;
    ex_ready_in = 1'b0;
    set_issue(1, 0, 0, 0, 0); step();
    set_issue(10, 6, 0, 0, 0); step();
    set_issue(11, 6, 0, 0, 0); step();
    set_issue(12, 6, 0, 0, 0); step(); idle();
    n_cmp++; if (count_out !== 5'd3 || ex_tag_out !== 4'd1) begin n_fail++; $display("FAIL age_fill: got cnt %0d tag %0d want 3 1", count_out, ex_tag_out); end
    set_cdb(2'b01, 6, 0, 32'h66, 0); step(); idle();
    n_cmp++; if (ex_valid_out !== 1'b1 || ex_tag_out !== 4'd1 || count_out !== 5'd3) begin n_fail++; $display("FAIL age_hold: got exv %0h tag %0d cnt %0d want 1 1 3", ex_valid_out, ex_tag_out, count_out); end
    ex_ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (ex_valid_out !== 1'b1 || ex_tag_out !== exp_tags[k] || ex_v1_out !== 32'h66) begin n_fail++; $display("FAIL age_order%0d: got exv %0h tag %0d v1 %0h want 1 %0d 66", k, ex_valid_out, ex_tag_out, ex_v1_out, exp_tags[k]); end
    end
    step();
    n_cmp++; if (ex_valid_out !== 1'b0 || count_out !== 5'd0) begin n_fail++; $display("FAIL age_end: got exv %0h cnt %0d want 0 0", ex_valid_out, count_out); end
  endtask

  task automatic test_full();
    ex_ready_in = 1'b1;
    for (int i = 0; i < D; i++) begin
      set_issue(QW'((i % 15) + 1), 9, 0, 0, 0); step();
    end
    idle();
    n_cmp++; if (count_out !== 5'd16 || issue_ready_out !== 1'b0) begin n_fail++; $display("FAIL full_cnt: got cnt %0d irdy %0h want 16 0", count_out, issue_ready_out); end
    set_issue(7, 0, 0, 0, 0); step(); idle();
    n_cmp++; if (count_out !== 5'd16 || ex_valid_out !== 1'b0) begin n_fail++; $display("FAIL full_refuse: got cnt %0d exv %0h want 16 0", count_out, ex_valid_out); end
    set_cdb(2'b01, 9, 0, 32'h99, 0); step(); idle();
    for (int k = 0; k < D; k++) begin
      step();
      n_cmp++; if (ex_valid_out !== 1'b1 || ex_tag_out !== QW'((k % 15) + 1) || ex_v1_out !== 32'h99 || count_out !== CW'(D - k - 1)) begin
        n_fail++; $display("FAIL full_disp%0d: got exv %0h tag %0d v1 %0h cnt %0d want 1 %0d 99 %0d", k, ex_valid_out, ex_tag_out, ex_v1_out, count_out, (k % 15) + 1, D - k - 1);
      end
    end
    step();
    n_cmp++; if (ex_valid_out !== 1'b0 || count_out !== 5'd0) begin n_fail++; $display("FAIL full_end: got exv %0h cnt %0d want 0 0", ex_valid_out, count_out); end
  endtask

  task automatic test_bypass();
    ex_ready_in = 1'b1;
    set_issue(5, 7, 8, 0, 0); set_cdb(2'b11, 7, 8, 32'hA, 32'hB); step(); idle();
    n_cmp++; if (count_out !== 5'd1 || ex_valid_out !== 1'b0) begin n_fail++; $display("FAIL byp_load: got cnt %0d exv %0h want 1 0", count_out, ex_valid_out); end
    step();
    n_cmp++; if (ex_valid_out !== 1'b1 || ex_tag_out !== 4'd5 || ex_v1_out !== 32'hA || ex_v2_out !== 32'hB) begin n_fail++; $display("FAIL byp_disp: got exv %0h tag %0d v1 %0h v2 %0h want 1 5 a b", ex_valid_out, ex_tag_out, ex_v1_out, ex_v2_out); end
    set_issue(6, 7, 0, 0, 0); step(); idle();
    set_cdb(2'b11, 7, 7, 32'h11, 32'h22); step(); idle();
    step();
    n_cmp++; if (ex_tag_out !== 4'd6 || ex_v1_out !== 32'h11) begin n_fail++; $display("FAIL byp_prio: got tag %0d v1 %0h want 6 11", ex_tag_out, ex_v1_out); end
    step();
    n_cmp++; if (ex_valid_out !== 1'b0 || count_out !== 5'd0) begin n_fail++; $display("FAIL byp_end: got exv %0h cnt %0d want 0 0", ex_valid_out, count_out); end
  endtask

  task automatic test_rdy_hold();
    ex_ready_in = 1'b0;
    set_issue(1, 0, 0, 0, 0); step();
    set_issue(2, 3, 0, 0, 0); step();
    rdy_in = 1'b0; ex_ready_in = 1'b1;
    set_issue(4, 0, 0, 0, 0); set_cdb(2'b01, 3, 0, 32'h33, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (count_out !== 5'd1 || ex_valid_out !== 1'b1 || ex_tag_out !== 4'd1 || issue_ready_out !== 1'b0) begin
        n_fail++; $display("FAIL hold%0d: got cnt %0d exv %0h tag %0d irdy %0h want 1 1 1 0", k, count_out, ex_valid_out, ex_tag_out, issue_ready_out);
      end
    end
    rdy_in = 1'b1; idle(); step();
    n_cmp++; if (ex_valid_out !== 1'b0 || count_out !== 5'd1) begin n_fail++; $display("FAIL hold_resume: got exv %0h cnt %0d want 0 1", ex_valid_out, count_out); end
    set_cdb(2'b01, 3, 0, 32'h33, 0); step(); idle();
    step();
    n_cmp++; if (ex_valid_out !== 1'b1 || ex_tag_out !== 4'd2 || ex_v1_out !== 32'h33 || count_out !== 5'd0) begin n_fail++; $display("FAIL hold_wake: got exv %0h tag %0d v1 %0h cnt %0d want 1 2 33 0", ex_valid_out, ex_tag_out, ex_v1_out, count_out); end
    step();
  endtask

  task automatic test_flush();
    ex_ready_in = 1'b0;
    set_issue(1, 0, 0, 0, 0); step();
    for (int t = 2; t <= 6; t++) begin
      set_issue(QW'(t), 9, 0, 0, 0); step();
    end
    idle();
    n_cmp++; if (count_out !== 5'd5 || ex_valid_out !== 1'b1 || ex_tag_out !== 4'd1) begin n_fail++; $display("FAIL flush_pre: got cnt %0d exv %0h tag %0d want 5 1 1", count_out, ex_valid_out, ex_tag_out); end
    flush_in = 1'b1; set_issue(7, 0, 0, 0, 0); step(); idle();
    n_cmp++; if (count_out !== 5'd0 || ex_valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_clr: got cnt %0d exv %0h want 0 0", count_out, ex_valid_out); end
    step();
    n_cmp++; if (count_out !== 5'd0 || ex_valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got cnt %0d exv %0h want 0 0", count_out, ex_valid_out); end
  endtask

  task automatic test_reset_mid();
    ex_ready_in = 1'b0;
    set_issue(2, 0, 0, 32'h55, 0); step(); idle(); step();
    n_cmp++; if (ex_valid_out !== 1'b1 || ex_v1_out !== 32'h55) begin n_fail++; $display("FAIL rst_pre: got exv %0h v1 %0h want 1 55", ex_valid_out, ex_v1_out); end
    #2 rst_n_in = 1'b0;
    #1;
    n_cmp++; if (ex_valid_out !== 1'b0 || count_out !== 5'd0 || ex_tag_out !== 4'd0 || ex_v1_out !== 32'd0) begin n_fail++; $display("FAIL rst_mid: got exv %0h cnt %0d tag %0d v1 %0h want 0 0 0 0", ex_valid_out, count_out, ex_tag_out, ex_v1_out); end
    @(negedge clk_in); rst_n_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_age();
    test_full();
    test_bypass();
    test_rdy_hold();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end
endmodule
